// File: rtl/valet_pkg.sv
// Shared types and helpers for the valet parking-lot controller.
package valet_pkg;

  localparam int unsigned PLATE_WIDTH = 16;
  localparam int unsigned CYCLE_WIDTH = 16;
  // Upper bound on slot count supported by the priority-encoder helpers.
  localparam int unsigned MAX_SLOTS   = 256;

  // Slot record as seen by the transaction log at default widths.
  typedef struct packed {
    logic                   occupied;
    logic [PLATE_WIDTH-1:0] plate;
    logic                   vip;
    logic [CYCLE_WIDTH-1:0] park_cycle;
  } slot_t;

  // Event kinds reported to the transaction log.
  typedef enum logic {
    EV_PARK     = 1'b0,
    EV_RETRIEVE = 1'b1
  } lot_event_e;

  // Lowest index i < n whose occupied bit is clear (0 if none).
  function automatic int unsigned lowest_free(input logic [MAX_SLOTS-1:0] occ,
                                              input int unsigned n);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = n; i > 0; i--) begin
      if (!occ[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

  // Lowest set bit of a match vector (0 if none).
  function automatic int unsigned lowest_match(input logic [MAX_SLOTS-1:0] match);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = MAX_SLOTS; i > 0; i--) begin
      if (match[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/valet_fifo.sv
// Parametrised wait queue: push/pop in the same cycle keeps the count unchanged.
module valet_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and fill-level bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/valet_lot_ctrl.sv
// Valet lot controller: VIP/standard wait queues, lowest-free-slot parking,
// plate-based retrieval with dwell measurement, and chaos lockdown.
module valet_lot_ctrl #(
  parameter int unsigned NUM_SLOTS   = 8,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned PLATE_W     = 16,
  parameter int unsigned CYCLE_W     = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               arrive_valid,
  input  logic [PLATE_W-1:0]                 arrive_plate,
  input  logic                               arrive_vip,
  output logic                               arrive_ready,
  input  logic                               retrieve_valid,
  input  logic [PLATE_W-1:0]                 retrieve_plate,
  input  logic                               chaos_en,
  output logic                               park_valid,
  output logic [$clog2(NUM_SLOTS)-1:0]       park_slot,
  output logic [PLATE_W-1:0]                 park_plate,
  output logic                               park_vip,
  output logic                               done_valid,
  output logic                               done_found,
  output logic [$clog2(NUM_SLOTS)-1:0]       done_slot,
  output logic [CYCLE_W-1:0]                 done_dwell,
  output logic [$clog2(NUM_SLOTS+1)-1:0]     occupancy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   vip_count,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   std_count
);
  import valet_pkg::*;

  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam int unsigned OCC_W  = $clog2(NUM_SLOTS+1);

  typedef struct packed {
    logic               occupied;
    logic [PLATE_W-1:0] plate;
    logic               vip;
    logic [CYCLE_W-1:0] park_cycle;
  } lot_slot_t;

  lot_slot_t          slots [NUM_SLOTS];
  logic [CYCLE_W-1:0] cycle_cnt;

  logic               vip_full, vip_empty, std_full, std_empty;
  logic [PLATE_W-1:0] vip_head, std_head;
  logic               vip_push, std_push;

  logic [NUM_SLOTS-1:0] occ;
  logic [NUM_SLOTS-1:0] match;
  logic                 any_free;
  logic                 hit;
  logic                 pop_vip;
  logic                 pop_std;
  logic                 do_park;
  logic [SLOT_W-1:0]    free_idx;
  logic [SLOT_W-1:0]    match_idx;
  logic [PLATE_W-1:0]   park_src_plate;

  assign arrive_ready = arrive_vip ? !vip_full : !std_full;
  assign vip_push     = arrive_valid && arrive_ready && arrive_vip;
  assign std_push     = arrive_valid && arrive_ready && !arrive_vip;

  valet_fifo #(.WIDTH(PLATE_W), .DEPTH(QUEUE_DEPTH)) u_vip_q (
    .clk(clk), .rst_n(rst_n), .push(vip_push), .push_data(arrive_plate),
    .pop(pop_vip), .head(vip_head), .full(vip_full), .empty(vip_empty),
    .count(vip_count)
  );

  valet_fifo #(.WIDTH(PLATE_W), .DEPTH(QUEUE_DEPTH)) u_std_q (
    .clk(clk), .rst_n(rst_n), .push(std_push), .push_data(arrive_plate),
    .pop(pop_std), .head(std_head), .full(std_full), .empty(std_empty),
    .count(std_count)
  );

  // Slot selection works off start-of-cycle occupancy, so a slot released by
  // retrieval this cycle is never the one chosen for parking this cycle.
  always_comb begin
    occ   = '0;
    match = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      occ[i]   = slots[i].occupied;
      match[i] = slots[i].occupied && (slots[i].plate == retrieve_plate);
    end
    any_free       = ~&occ;
    free_idx       = SLOT_W'(lowest_free(MAX_SLOTS'(occ), NUM_SLOTS));
    match_idx      = SLOT_W'(lowest_match(MAX_SLOTS'(match)));
    hit            = retrieve_valid && (|match);
    pop_vip        = any_free && !vip_empty;
    pop_std        = any_free && vip_empty && !std_empty && !chaos_en;
    do_park        = pop_vip || pop_std;
    park_src_plate = pop_vip ? vip_head : std_head;
  end

  // Slot table, cycle counter, occupancy and registered event outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      cycle_cnt  <= '0;
      occupancy  <= '0;
      park_valid <= 1'b0;
      park_slot  <= '0;
      park_plate <= '0;
      park_vip   <= 1'b0;
      done_valid <= 1'b0;
      done_found <= 1'b0;
      done_slot  <= '0;
      done_dwell <= '0;
    end else begin
      cycle_cnt  <= cycle_cnt + CYCLE_W'(1);
      occupancy  <= occupancy + OCC_W'(do_park) - OCC_W'(hit);
      park_valid <= do_park;
      if (do_park) begin
        slots[free_idx] <= '{occupied: 1'b1, plate: park_src_plate,
                             vip: pop_vip, park_cycle: cycle_cnt};
        park_slot  <= free_idx;
        park_plate <= park_src_plate;
        park_vip   <= pop_vip;
      end
      if (hit) slots[match_idx].occupied <= 1'b0;
      done_valid <= retrieve_valid;
      done_found <= hit;
      done_slot  <= hit ? match_idx : '0;
      done_dwell <= hit ? (cycle_cnt - slots[match_idx].park_cycle) : '0;
    end
  end

endmodule

// File: tb/tb_valet_lot_ctrl.sv
// Randomised scoreboard bench for valet_lot_ctrl with a queue/array model.
module tb_valet_lot_ctrl;

  localparam int NS    = 8;
  localparam int QD    = 4;
  localparam int PW    = 16;
  localparam int CW    = 8;
  localparam int CMASK = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arrive_valid = 1'b0;
  logic [PW-1:0] arrive_plate = '0;
  logic arrive_vip = 1'b0;
  logic arrive_ready;
  logic retrieve_valid = 1'b0;
  logic [PW-1:0] retrieve_plate = '0;
  logic chaos_en = 1'b0;
  logic park_valid;
  logic [$clog2(NS)-1:0] park_slot;
  logic [PW-1:0] park_plate;
  logic park_vip;
  logic done_valid;
  logic done_found;
  logic [$clog2(NS)-1:0] done_slot;
  logic [CW-1:0] done_dwell;
  logic [$clog2(NS+1)-1:0] occupancy;
  logic [$clog2(QD+1)-1:0] vip_count;
  logic [$clog2(QD+1)-1:0] std_count;

  always #5 clk = ~clk;

  valet_lot_ctrl #(.NUM_SLOTS(NS), .QUEUE_DEPTH(QD), .PLATE_W(PW), .CYCLE_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .arrive_valid(arrive_valid), .arrive_plate(arrive_plate), .arrive_vip(arrive_vip),
    .arrive_ready(arrive_ready),
    .retrieve_valid(retrieve_valid), .retrieve_plate(retrieve_plate),
    .chaos_en(chaos_en),
    .park_valid(park_valid), .park_slot(park_slot), .park_plate(park_plate), .park_vip(park_vip),
    .done_valid(done_valid), .done_found(done_found), .done_slot(done_slot), .done_dwell(done_dwell),
    .occupancy(occupancy), .vip_count(vip_count), .std_count(std_count)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  typedef struct { int due; int slot; int plate; int vip; } park_exp_t;
  typedef struct { int due; int found; int slot; int dwell; } done_exp_t;
  park_exp_t pq[$];
  done_exp_t dq[$];

  // Reference model state
  int  vq[$];
  int  sq[$];
  bit  m_occ[NS];
  int  m_plate[NS];
  int  m_pc[NS];
  int  mc = 0;
  bit  primed = 1'b0;
  bit  chaos_state = 1'b0;

  task automatic step(input bit rst, input bit av, input int ap, input bit avip,
                      input bit rv, input int rp, input bit ch);
    int occ_n;
    bit ready;
    int f;
    int m;
    int pp;
    bit pvip;
    bit parked;
    park_exp_t pe;
    done_exp_t de;
    @(negedge clk);
    if (primed) begin
      occ_n = 0;
      foreach (m_occ[i]) if (m_occ[i]) occ_n++;
      check("occupancy", int'(occupancy), occ_n);
      check("vip_count", int'(vip_count), vq.size());
      check("std_count", int'(std_count), sq.size());
    end
    rst_n          = !rst;
    arrive_valid   = av;
    arrive_plate   = PW'(ap);
    arrive_vip     = avip;
    retrieve_valid = rv;
    retrieve_plate = PW'(rp);
    chaos_en       = ch;
    #1;
    if (rst) begin
      vq.delete();
      sq.delete();
      foreach (m_occ[i]) m_occ[i] = 1'b0;
      mc = 0;
      primed = 1'b1;
      return;
    end
    ready = avip ? (vq.size() < QD) : (sq.size() < QD);
    check("arrive_ready", int'(arrive_ready), int'(ready));
    m = -1;
    if (rv) begin
      for (int i = NS - 1; i >= 0; i--) if (m_occ[i] && m_plate[i] == rp) m = i;
      if (m >= 0) de = '{cyc + 1, 1, m, (mc - m_pc[m]) & CMASK};
      else        de = '{cyc + 1, 0, 0, 0};
      dq.push_back(de);
    end
    f = -1;
    for (int i = NS - 1; i >= 0; i--) if (!m_occ[i]) f = i;
    parked = 1'b0;
    pp = 0;
    pvip = 1'b0;
    if (f >= 0) begin
      if (vq.size() > 0) begin
        pp = vq.pop_front(); pvip = 1'b1; parked = 1'b1;
      end else if (sq.size() > 0 && !ch) begin
        pp = sq.pop_front(); pvip = 1'b0; parked = 1'b1;
      end
    end
    if (parked) begin
      pe = '{cyc + 1, f, pp, int'(pvip)};
      pq.push_back(pe);
      m_occ[f] = 1'b1;
      m_plate[f] = pp;
      m_pc[f] = mc;
    end
    if (m >= 0) m_occ[m] = 1'b0;
    if (av && ready) begin
      if (avip) vq.push_back(ap);
      else      sq.push_back(ap);
    end
    mc = (mc + 1) & CMASK;
  endtask

  // Monitor: compares pulses against the scoreboard queues, including timing.
  always @(negedge clk) begin
    if (cyc >= 2) begin
      if (pq.size() > 0 && pq[0].due == cyc) begin
        check("park_valid", int'(park_valid), 1);
        check("park_slot", int'(park_slot), pq[0].slot);
        check("park_plate", int'(park_plate), pq[0].plate);
        check("park_vip", int'(park_vip), pq[0].vip);
        void'(pq.pop_front());
      end else begin
        check("park_idle", int'(park_valid), 0);
      end
      if (dq.size() > 0 && dq[0].due == cyc) begin
        check("done_valid", int'(done_valid), 1);
        check("done_found", int'(done_found), dq[0].found);
        check("done_slot", int'(done_slot), dq[0].slot);
        check("done_dwell", int'(done_dwell), dq[0].dwell);
        void'(dq.pop_front());
      end else begin
        check("done_idle", int'(done_valid), 0);
      end
    end
  end

  task automatic run_random(input int n, input int p_arr, input int p_vip,
                            input int p_ret, input int chaos_mode);
    for (int i = 0; i < n; i++) begin
      if (chaos_mode == 0) chaos_state = 1'b0;
      else if (chaos_mode == 1) chaos_state = 1'b1;
      else if ($urandom_range(99) < 5) chaos_state = !chaos_state;
      step(1'b0,
           $urandom_range(99) < p_arr, int'($urandom_range(15)), $urandom_range(99) < p_vip,
           $urandom_range(99) < p_ret,
           ($urandom_range(19) == 0) ? 999 : int'($urandom_range(15)),
           chaos_state);
    end
  endtask

  initial begin
    step(1'b1, 0, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0, 0, 0);
    // Single standard arrival, then a quiet spell for it to park.
    step(1'b0, 1, 100, 0, 0, 0, 0);
    repeat (3) step(1'b0, 0, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 1, 100, 0);
    step(1'b0, 0, 0, 0, 1, 999, 0);
    // Fill the lot and both queues, then free slots one at a time.
    run_random(40, 90, 30, 0, 0);
    run_random(60, 80, 40, 25, 0);
    // Lockdown: standard arrivals pile up while VIPs still park.
    run_random(60, 70, 20, 30, 1);
    run_random(40, 20, 20, 30, 0);
    // Mid-operation reset with a populated lot.
    run_random(30, 90, 30, 5, 0);
    step(1'b1, 1, 5, 0, 1, 5, 0);
    // Long mixed traffic: several counter wraps, chaos toggling.
    run_random(2000, 50, 25, 25, 2);
    // Drain.
    run_random(200, 0, 0, 80, 0);
    repeat (3) step(1'b0, 0, 0, 0, 0, 0, 0);
    check("park_pending", pq.size(), 0);
    check("done_pending", dq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
